// File: rtl/jam_cost_arbiter.sv
// Round-robin arbiter that shares one cost-matrix read port among NUM_REQ requesters.
// Each grant is an 8-beat row burst (J=0..7). Back-to-back bursts run with no idle cycle.
module jam_cost_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int COST_W  = 7
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   row,
  output logic [2:0]             W,
  output logic [2:0]             J,
  input  logic [COST_W-1:0]      Cost,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [2:0]             rsp_col,
  output logic [COST_W-1:0]      rsp_data,
  output logic [NUM_REQ-1:0]     done
);

  localparam int PW = 2;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e             state_q;
  logic [PW-1:0]      ptr_q;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [2:0]         win_row;

  // The finishing owner is masked in its last-beat cycle and in its done cycle.
  always_comb begin
    mask = done;
    if (state_q == StBurst && J == 3'd7) begin
      mask = mask | gnt;
    end
    elig      = req & ~mask;
    win_found = 1'b0;
    win_oh    = '0;
    win_idx   = '0;
    win_row   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && elig[i] && (i == (int'(ptr_q) + k) % NUM_REQ)) begin
          win_found = 1'b1;
          win_oh[i] = 1'b1;
          win_idx   = PW'(i);
          win_row   = row[3*i +: 3];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      ptr_q     <= PW'(NUM_REQ - 1);
      W         <= '0;
      J         <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= '0;
      rsp_col   <= '0;
      rsp_data  <= '0;
      done      <= '0;
    end else begin
      rsp_valid <= '0;
      done      <= '0;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            gnt     <= win_oh;
            W       <= win_row;
            J       <= 3'd0;
            busy    <= 1'b1;
            ptr_q   <= win_idx;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          rsp_valid <= gnt;
          rsp_col   <= J;
          rsp_data  <= Cost;
          if (J == 3'd7) begin
            done <= gnt;
            J    <= 3'd0;
            if (win_found) begin
              gnt   <= win_oh;
              W     <= win_row;
              ptr_q <= win_idx;
            end else begin
              gnt     <= '0;
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            J <= J + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Self-checking bench for jam_cost_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_jam_cost_arbiter;
  localparam int NR = 2;
  localparam int CW = 7;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NR-1:0]   req;
  logic [3*NR-1:0] row;
  logic [2:0]      W, J;
  logic [CW-1:0]   Cost;
  logic [NR-1:0]   gnt, rsp_valid, done;
  logic            busy;
  logic [2:0]      rsp_col;
  logic [CW-1:0]   rsp_data;

  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b0;

  // Cost matrix stand-in: entry = 8*W + J.
  assign Cost = CW'({W, J});

  always #5 CLK = ~CLK;

  jam_cost_arbiter #(.NUM_REQ(NR), .COST_W(CW)) dut (
    .CLK(CLK), .RST(RST), .req(req), .row(row), .W(W), .J(J), .Cost(Cost),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_col(rsp_col),
    .rsp_data(rsp_data), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req = '0;
    row = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic set_row(input int i, input int v);
    row[3*i +: 3] = 3'(v);
  endtask

  task automatic beat(input string nm, input int oh, input int col, input int data,
                      input int dn);
    tick();
    chk({nm, " rsp_valid"}, int'(rsp_valid), oh);
    chk({nm, " rsp_col"}, int'(rsp_col), col);
    chk({nm, " rsp_data"}, int'(rsp_data), data);
    chk({nm, " done"}, int'(done), dn);
  endtask

  // Reference model: tracks owner, beat number and round-robin pointer as plain integers.
  int m_owner, m_beat, m_row, m_rr, m_done;
  int e_rv, e_col, e_data;
  int nxt, cand, last_o;

  always @(posedge CLK) begin
    if (RST) begin
      m_owner = -1; m_beat = 0; m_row = 0; m_rr = NR - 1; m_done = -1;
      e_rv = 0; e_col = 0; e_data = 0;
    end else begin
      last_o = (m_owner >= 0 && m_beat == 7) ? m_owner : -1;
      if (m_owner >= 0) begin
        e_rv = 1 << m_owner; e_col = m_beat; e_data = 8 * m_row + m_beat;
      end else begin
        e_rv = 0;
      end
      if (m_owner < 0 || m_beat == 7) begin
        nxt = -1;
        for (int k = 1; k <= NR; k++) begin
          cand = (m_rr + k) % NR;
          if (nxt < 0 && ((int'(req) >> cand) & 1) == 1 && cand != last_o && cand != m_done)
            nxt = cand;
        end
        m_owner = nxt;
        m_beat  = 0;
        if (nxt >= 0) begin
          m_row = (int'(row) >> (3 * nxt)) & 7;
          m_rr  = nxt;
        end
      end else begin
        m_beat++;
      end
      m_done = last_o;
    end
  end

  always @(negedge CLK) begin
    if (model_on) begin
      int e_gnt, e_done;
      bit ok;
      e_gnt  = (m_owner >= 0) ? (1 << m_owner) : 0;
      e_done = (m_done >= 0) ? (1 << m_done) : 0;
      ok = int'(gnt) == e_gnt && int'(busy) == (m_owner >= 0 ? 1 : 0) &&
           int'(W) == m_row && int'(J) == m_beat && int'(rsp_valid) == e_rv &&
           int'(done) == e_done;
      if (e_rv != 0) ok = ok && int'(rsp_col) == e_col && int'(rsp_data) == e_data;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL model t=%0t: got gnt=%0d busy=%0d W=%0d J=%0d rv=%0d col=%0d data=%0d done=%0d expected gnt=%0d busy=%0d W=%0d J=%0d rv=%0d col=%0d data=%0d done=%0d",
                 $time, gnt, busy, W, J, rsp_valid, rsp_col, rsp_data, done,
                 e_gnt, (m_owner >= 0), m_row, m_beat, e_rv, e_col, e_data, e_done);
      end
    end
  end

  typedef struct {
    logic [NR-1:0] rq;
    int r0;
    int r1;
    int owner;
    int base;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{rq: 2'b01, r0: 3, r1: 0, owner: 0, base: 24};
    vecs[1] = '{rq: 2'b10, r0: 0, r1: 5, owner: 1, base: 40};
    vecs[2] = '{rq: 2'b01, r0: 7, r1: 1, owner: 0, base: 56};
    vecs[3] = '{rq: 2'b10, r0: 4, r1: 2, owner: 1, base: 16};
    vecs[4] = '{rq: 2'b01, r0: 0, r1: 6, owner: 0, base: 0};

    // Reset state
    do_reset();
    chk("rst W", int'(W), 0);
    chk("rst J", int'(J), 0);
    chk("rst gnt", int'(gnt), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst rsp_valid", int'(rsp_valid), 0);
    chk("rst rsp_data", int'(rsp_data), 0);
    chk("rst done", int'(done), 0);

    // Single-requester bursts from reset
    foreach (vecs[v]) begin
      do_reset();
      req = vecs[v].rq;
      set_row(0, vecs[v].r0);
      set_row(1, vecs[v].r1);
      tick();
      chk("tbl gnt", int'(gnt), 1 << vecs[v].owner);
      chk("tbl busy", int'(busy), 1);
      chk("tbl W", int'(W), vecs[v].owner == 0 ? vecs[v].r0 : vecs[v].r1);
      chk("tbl J", int'(J), 0);
      for (int b = 0; b < 8; b++)
        beat("tbl", 1 << vecs[v].owner, b, vecs[v].base + b, b == 7 ? (1 << vecs[v].owner) : 0);
      chk("tbl idle busy", int'(busy), 0);
      req = '0;
      tick();
      chk("tbl idle gnt", int'(gnt), 0);
      chk("tbl idle rv", int'(rsp_valid), 0);
      chk("tbl idle done", int'(done), 0);
    end

    // Back-to-back bursts, each requester drops on its done
    do_reset();
    req = 2'b11; set_row(0, 1); set_row(1, 5);
    tick();
    chk("b2b gnt0", int'(gnt), 1);
    for (int i = 0; i < 16; i++) begin
      beat("b2b", i < 8 ? 1 : 2, i % 8, i < 8 ? 8 + i : 40 + i - 8,
           i == 7 ? 1 : (i == 15 ? 2 : 0));
      if (i == 7) begin
        chk("b2b gnt1", int'(gnt), 2);
        req = 2'b10;
      end
      if (i == 15) req = 2'b00;
    end
    chk("b2b idle busy", int'(busy), 0);

    // Requests never dropped: grants alternate
    do_reset();
    req = 2'b11; set_row(0, 0); set_row(1, 1);
    tick();
    for (int i = 0; i < 32; i++) begin
      int o;
      o = (i / 8) % 2;
      beat("alt", 1 << o, i % 8, 8 * o + i % 8, (i % 8 == 7) ? (1 << o) : 0);
    end

    // Owner holds req through done: re-grant two cycles after done, row re-sampled
    do_reset();
    req = 2'b01; set_row(0, 2);
    tick();
    for (int b = 0; b < 8; b++) beat("regnt", 1, b, 16 + b, b == 7 ? 1 : 0);
    set_row(0, 6);
    tick();
    chk("regnt masked gnt", int'(gnt), 0);
    chk("regnt masked busy", int'(busy), 0);
    tick();
    chk("regnt gnt", int'(gnt), 1);
    chk("regnt W", int'(W), 6);
    beat("regnt2", 1, 0, 48, 0);

    // Row change and req drop mid-burst are ignored
    do_reset();
    req = 2'b01; set_row(0, 2);
    tick();
    for (int b = 0; b < 8; b++) begin
      if (b == 3) begin
        set_row(0, 6);
        req = 2'b00;
      end
      beat("hold", 1, b, 16 + b, b == 7 ? 1 : 0);
    end
    chk("hold busy", int'(busy), 0);

    // Reset in the middle of a burst
    do_reset();
    req = 2'b01; set_row(0, 3);
    tick();
    for (int b = 0; b < 4; b++) beat("mrst", 1, b, 24 + b, 0);
    chk("mrst J4", int'(J), 4);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mrst W", int'(W), 0);
    chk("mrst J", int'(J), 0);
    chk("mrst gnt", int'(gnt), 0);
    chk("mrst busy", int'(busy), 0);
    chk("mrst rv", int'(rsp_valid), 0);
    chk("mrst col", int'(rsp_col), 0);
    chk("mrst data", int'(rsp_data), 0);
    chk("mrst done", int'(done), 0);
    req = 2'b11; set_row(0, 5); set_row(1, 2);
    tick();
    chk("mrst regnt", int'(gnt), 1);
    chk("mrst regnt W", int'(W), 5);
    chk("mrst regnt J", int'(J), 0);
    beat("mrst beat", 1, 0, 40, 0);

    // Randomized traffic against the reference model
    do_reset();
    model_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK);
      #1;
      RST = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) req = NR'($urandom);
      if ($urandom_range(0, 1) == 0) row = (3*NR)'($urandom);
    end
    @(posedge CLK);
    #1;
    model_on = 1'b0;
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
